mul_iter: RTL and testbench
===========================

MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; even, 8..64.
REQ-002 SHALL have parameter BPC, default 1, multiplier bits retired per cycle; 1 or 2 (radix-2 / radix-4).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request; accepted only when ready=1.
REQ-006 SHALL have port is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 SHALL have port op  in  2  00 MUL, 01 MADD (acc + a*b), 10 MSUB (acc - a*b), 11 treated as MUL.
REQ-008 SHALL have port a, b  in  WIDTH  multiplicand, multiplier.
REQ-009 SHALL have port acc_hi, acc_lo  in  WIDTH each  accumulator {acc_hi,acc_lo}, used by MADD/MSUB.
REQ-010 SHALL have port flush  in  1  abort in-flight operation.
REQ-011 SHALL have port ready  out  1  high in IDLE.
REQ-012 SHALL have port done  out  1  one-cycle pulse when a result is written.
REQ-013 SHALL have port mul_hi, mul_lo  out  WIDTH each  registered result {mul_hi,mul_lo}.

Function
REQ-014 SHALL implement states IDLE, RUN, FIX; reset enters IDLE.
REQ-015 On an edge with state IDLE, start=1 and flush=0: SHALL latch is_signed, op, acc_hi/acc_lo, |a|, |b| (magnitude only if is_signed and MSB set), and sign = is_signed & (a[W-1]^b[W-1]); SHALL load iteration counter N = WIDTH/BPC; SHALL enter RUN.
REQ-016 Magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) as an unsigned WIDTH-bit value (no overflow).
REQ-017 In RUN, each edge SHALL retire BPC multiplier bits (shift-add; for BPC=2 add 0/1/2/3 x |a|, 2W+2-bit internal sum) and decrement the counter; on the edge the counter reaches 0, SHALL enter FIX.
REQ-018 In FIX, on one edge: product P = sign ? -mag : mag (2W bits); result = P, acc+P, or acc-P for MUL/MADD/MSUB, modulo 2^(2W); SHALL write mul_hi/mul_lo, set done=1, enter IDLE.
REQ-019 Latency: start sampled on edge 0 -> result and done visible after edge WIDTH/BPC+1 (33 for 32/1, 17 for 32/2).
REQ-020 done SHALL be high exactly one cycle per completed operation; ready SHALL be high during that same cycle.
REQ-021 Back-to-back: start with done=1 SHALL be accepted; new operation runs, old result held until overwritten.
REQ-022 mul_hi/mul_lo SHALL change only in FIX or reset; held stable otherwise, including during RUN.
REQ-023 start while ready=0 SHALL be ignored, not queued.
REQ-024 flush=1 in RUN or FIX SHALL return to IDLE on that edge; no done, results unchanged.
REQ-025 flush=1 and start=1 in IDLE on the same edge: flush wins, start not accepted.
REQ-026 Inputs a, b, is_signed, op, acc_* MAY change after acceptance without affecting the operation in flight.

Reset
REQ-027 reset=1 SHALL force IDLE, counter 0, mul_hi=0, mul_lo=0, done=0, ready=1 after the edge, regardless of state; overrides start and flush.
REQ-028 Reset mid-RUN SHALL discard the operation; no done afterward.

Verification
REQ-029 WIDTH=32, BPC=1, unsigned MUL 0xFFFFFFFF x 0xFFFFFFFF -> done after edge 33, {hi,lo}=0xFFFFFFFE_00000001, ready low for edges 1..33.
REQ-030 Signed MUL 0x80000000 x 0xFFFFFFFF (-2^31 x -1) -> {hi,lo}=0x00000000_80000000; signed -3 x 5 -> 0xFFFFFFFF_FFFFFFF1.
REQ-031 MADD acc=0x00000000_FFFFFFFF, a=1, b=1 unsigned -> 0x00000001_00000000; MSUB acc=0, a=2, b=3 signed -> 0xFFFFFFFF_FFFFFFFA.
REQ-032 BPC=2: unsigned 0x12345678 x 0x9ABCDEF0 -> 0x0B00EA4E_242D2080, done after edge 17; random 10k compare vs reference model for BPC 1/2, WIDTH 8/32.
REQ-033 Flush at edge 10 of RUN -> no done, ready high after edge 10, prior result unchanged; start+flush in IDLE -> no acceptance.
REQ-034 Reset at edge 20 of RUN -> outputs 0, ready=1, no done; start on done cycle -> second result after 33 more edges.

Source files
------------

// File: rtl/mul_iter_if.sv
// Operand/result bundle for the iterative multiplier; master drives requests, slave is the datapath.
interface mul_iter_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             flush;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  modport master (
    output start, is_signed, op, a, b, acc_hi, acc_lo, flush,
    input  ready, done, mul_hi, mul_lo
  );

  modport slave (
    input  start, is_signed, op, a, b, acc_hi, acc_lo, flush,
    output ready, done, mul_hi, mul_lo
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier with multiply-accumulate/subtract; retires BPC multiplier bits per cycle
// on magnitudes, then applies sign and accumulator in a single fix-up cycle.
module mul_iter #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input logic       clock,
  input logic       reset,
  mul_iter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SUM_W = WIDTH + BPC;
  localparam int P_W   = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             sign_q, sign_d;
  logic [1:0]       op_q, op_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [P_W-1:0]   prod_q, prod_d;

  logic [SUM_W-1:0] addend, sum_hi;
  logic [P_W-1:0]   prod_signed, result;

  // -2^(WIDTH-1) maps onto itself, which reads correctly as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (WIDTH'(0) - v) : v;
  endfunction

  // prod_q holds {partial sum, unretired multiplier bits}; the low BPC bits select the addend.
  always_comb begin
    addend = '0;
    if (prod_q[0]) addend = addend + SUM_W'(mag_a_q);
    if (BPC == 2 && prod_q[1]) addend = addend + SUM_W'({mag_a_q, 1'b0});
    sum_hi = SUM_W'(prod_q[P_W-1:WIDTH]) + addend;

    prod_signed = sign_q ? (P_W'(0) - prod_q) : prod_q;
    case (op_q)
      2'b01:   result = acc_q + prod_signed;
      2'b10:   result = acc_q - prod_signed;
      default: result = prod_signed;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          sign_d  = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          op_d    = bus.op;
          acc_d   = {bus.acc_hi, bus.acc_lo};
          mag_a_d = mag_of(bus.a, bus.is_signed);
          prod_d  = {WIDTH'(0), mag_of(bus.b, bus.is_signed)};
          cnt_d   = CNT_W'(WIDTH / BPC);
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          prod_d = {sum_hi, prod_q[WIDTH-1:BPC]};
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          hi_d   = result[P_W-1:WIDTH];
          lo_d   = result[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Operand/working registers are only meaningful once an operation is accepted.
  always_ff @(posedge clock) begin
    sign_q  <= sign_d;
    op_q    <= op_d;
    acc_q   <= acc_d;
    mag_a_q <= mag_a_d;
    prod_q  <= prod_d;
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = done_q;
  assign bus.mul_hi = hi_q;
  assign bus.mul_lo = lo_q;
endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: four configurations (32/1, 32/2, 8/1, 8/2) driven in lockstep against an
// arithmetic reference model, plus directed flush, reset and back-to-back scenarios on the 32/1 unit.
module tb_mul_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, is_signed, flush;
  logic [1:0]  op;
  logic [63:0] a, b, acc;

  mul_iter_if #(.WIDTH(32)) if0 ();
  mul_iter_if #(.WIDTH(32)) if1 ();
  mul_iter_if #(.WIDTH(8))  if2 ();
  mul_iter_if #(.WIDTH(8))  if3 ();

  mul_iter #(.WIDTH(32), .BPC(1)) u0 (.clock(clk), .reset(rst), .bus(if0));
  mul_iter #(.WIDTH(32), .BPC(2)) u1 (.clock(clk), .reset(rst), .bus(if1));
  mul_iter #(.WIDTH(8),  .BPC(1)) u2 (.clock(clk), .reset(rst), .bus(if2));
  mul_iter #(.WIDTH(8),  .BPC(2)) u3 (.clock(clk), .reset(rst), .bus(if3));

  assign if0.start = start; assign if0.is_signed = is_signed; assign if0.op = op; assign if0.flush = flush;
  assign if1.start = start; assign if1.is_signed = is_signed; assign if1.op = op; assign if1.flush = flush;
  assign if2.start = start; assign if2.is_signed = is_signed; assign if2.op = op; assign if2.flush = flush;
  assign if3.start = start; assign if3.is_signed = is_signed; assign if3.op = op; assign if3.flush = flush;
  assign if0.a = a[31:0]; assign if0.b = b[31:0]; assign if0.acc_hi = acc[63:32]; assign if0.acc_lo = acc[31:0];
  assign if1.a = a[31:0]; assign if1.b = b[31:0]; assign if1.acc_hi = acc[63:32]; assign if1.acc_lo = acc[31:0];
  assign if2.a = a[7:0];  assign if2.b = b[7:0];  assign if2.acc_hi = acc[15:8];  assign if2.acc_lo = acc[7:0];
  assign if3.a = a[7:0];  assign if3.b = b[7:0];  assign if3.acc_hi = acc[15:8];  assign if3.acc_lo = acc[7:0];

  logic [3:0]  d_out, rdy;
  logic [63:0] r_out [4];
  assign d_out = {if3.done, if2.done, if1.done, if0.done};
  assign rdy   = {if3.ready, if2.ready, if1.ready, if0.ready};
  assign r_out[0] = {if0.mul_hi, if0.mul_lo};
  assign r_out[1] = {if1.mul_hi, if1.mul_lo};
  assign r_out[2] = {48'd0, if2.mul_hi, if2.mul_lo};
  assign r_out[3] = {48'd0, if3.mul_hi, if3.mul_lo};

  localparam int CFG_W   [4] = '{32, 32, 8, 8};
  localparam int CFG_LAT [4] = '{33, 17, 9, 5};

  int checks = 0;
  int errors = 0;
  logic [63:0] last_res [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sign-extend to 128 bits, multiply as integers, then reduce modulo 2^(2w).
  function automatic logic [63:0] model(input int w, input logic s, input logic [1:0] o,
                                        input logic [63:0] aa, input logic [63:0] bb, input logic [63:0] ac);
    logic [127:0] ea, eb, p, r, m1, m2;
    m1 = (128'd1 << w) - 128'd1;
    m2 = (128'd1 << (2 * w)) - 128'd1;
    ea = {64'd0, aa} & m1;
    eb = {64'd0, bb} & m1;
    if (s && ea[w-1]) ea = ea - (128'd1 << w);
    if (s && eb[w-1]) eb = eb - (128'd1 << w);
    p = ea * eb;
    case (o)
      2'b01:   r = ({64'd0, ac} & m2) + p;
      2'b10:   r = ({64'd0, ac} & m2) - p;
      default: r = p;
    endcase
    r = r & m2;
    return r[63:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic s, input logic [1:0] o, input logic [63:0] aa,
                       input logic [63:0] bb, input logic [63:0] ac);
    int got [4];
    int pulses [4];
    logic early [4];
    logic [63:0] res [4];
    for (int i = 0; i < 4; i++) begin got[i] = 0; pulses[i] = 0; early[i] = 1'b0; res[i] = '0; end
    start = 1'b1; is_signed = s; op = o; a = aa; b = bb; acc = ac;
    step();
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; acc = {$urandom, $urandom};
    is_signed = 1'($urandom); op = 2'($urandom);
    for (int k = 1; k <= 34; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (d_out[i]) begin
          pulses[i]++;
          if (got[i] == 0) begin got[i] = k; res[i] = r_out[i]; end
        end
        if (k < CFG_LAT[i] && rdy[i]) early[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("latency[%0d]", i), 64'(got[i]), 64'(CFG_LAT[i]));
      chk($sformatf("done_pulses[%0d]", i), 64'(pulses[i]), 64'd1);
      chk($sformatf("ready_busy[%0d]", i), 64'(early[i]), 64'd0);
      chk($sformatf("result[%0d]", i), res[i], model(CFG_W[i], s, o, aa, bb, ac));
      last_res[i] = res[i];
    end
  endtask

  initial begin
    int cnt;
    logic [63:0] prior;
    logic [63:0] corners [5];
    corners[0] = 64'h0; corners[1] = 64'h1; corners[2] = 64'h7FFF_FFFF;
    corners[3] = 64'h8000_0000; corners[4] = 64'hFFFF_FFFF;
    start = 1'b0; is_signed = 1'b0; op = 2'b00; flush = 1'b0; a = '0; b = '0; acc = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_ready", 64'(rdy), 64'hF);
    chk("reset_done", 64'(d_out), 64'h0);
    chk("reset_result", r_out[0], 64'h0);

    do_op(1'b0, 2'b00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0);
    chk("umul_max", last_res[0], 64'hFFFF_FFFE_0000_0001);
    do_op(1'b1, 2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0);
    chk("smul_minneg", last_res[0], 64'h0000_0000_8000_0000);
    do_op(1'b1, 2'b00, 64'hFFFF_FFFD, 64'h5, 64'h0);
    chk("smul_m3x5", last_res[0], 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(1'b0, 2'b01, 64'h1, 64'h1, 64'h0000_0000_FFFF_FFFF);
    chk("madd_carry", last_res[0], 64'h0000_0001_0000_0000);
    do_op(1'b1, 2'b10, 64'h2, 64'h3, 64'h0);
    chk("msub_neg", last_res[0], 64'hFFFF_FFFF_FFFF_FFFA);
    do_op(1'b0, 2'b00, 64'h1234_5678, 64'h9ABC_DEF0, 64'h0);
    chk("radix4_vec", last_res[1], 64'h0B00_EA4E_242D_2080);

    // Flush sampled on edge 10 of the run.
    prior = r_out[0];
    start = 1'b1; a = 64'h1234; b = 64'h5678; op = 2'b00; is_signed = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    chk("run_hold", r_out[0], prior);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", 64'(rdy[0]), 64'd1);
    chk("flush_result", r_out[0], prior);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(); if (d_out[0]) cnt++; end
    chk("flush_no_done", 64'(cnt), 64'd0);

    // Start and flush together in IDLE must not launch an operation.
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("startflush_ready", 64'(rdy), 64'hF);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(); if (d_out != 4'h0) cnt++; end
    chk("startflush_no_done", 64'(cnt), 64'd0);

    // Reset sampled on edge 20 of the run.
    start = 1'b1; a = 64'hFFFF_FFFF; b = 64'h3;
    step();
    start = 1'b0;
    for (int k = 1; k <= 19; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_result", r_out[0], 64'h0);
    chk("midrst_ready", 64'(rdy[0]), 64'd1);
    chk("midrst_done", 64'(d_out[0]), 64'd0);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin step(); if (d_out[0]) cnt++; end
    chk("midrst_no_done", 64'(cnt), 64'd0);

    // Back-to-back: new start presented in the done cycle.
    start = 1'b1; is_signed = 1'b0; op = 2'b00; a = 64'd7; b = 64'd9;
    step();
    start = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 40 && cnt == 0; k++) begin step(); if (d_out[0]) cnt = k; end
    chk("b2b_first_lat", 64'(cnt), 64'd33);
    chk("b2b_first_res", r_out[0], 64'd63);
    start = 1'b1; a = 64'd5; b = 64'd5;
    step();
    start = 1'b0;
    chk("b2b_accepted", 64'(rdy[0]), 64'd0);
    chk("b2b_held", r_out[0], 64'd63);
    cnt = 0;
    for (int k = 1; k <= 40 && cnt == 0; k++) begin step(); if (d_out[0]) cnt = k; end
    chk("b2b_second_lat", 64'(cnt), 64'd33);
    chk("b2b_second_res", r_out[0], 64'd25);
    for (int k = 0; k < 40; k++) step();

    for (int n = 0; n < 300; n++) begin
      logic [63:0] ra, rb;
      ra = {32'd0, $urandom};
      rb = {32'd0, $urandom};
      if (n % 4 == 0) ra = corners[$urandom_range(0, 4)];
      if (n % 4 == 1) rb = corners[$urandom_range(0, 4)];
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, rb, {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
